gene_unpacker: RTL



---
 rtl/gene_pkg.sv | 31 +++
 rtl/gene_lane_decode.sv | 13 +
 rtl/gene_unpacker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/gene_pkg.sv
// Shared definitions for the gene unpacker: 2-bit base codes, their ASCII
// characters, the code-to-character lookup and the FSM state type.
package gene_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_T = 2'd2;
  localparam logic [1:0] BASE_G = 2'd3;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_G = 8'h47;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [7:0] base2ascii(input logic [1:0] base);
    logic [7:0] ch;
    case (base)
      BASE_A:  ch = ASCII_A;
      BASE_C:  ch = ASCII_C;
      BASE_T:  ch = ASCII_T;
      default: ch = ASCII_G;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/gene_lane_decode.sv
// One output lane: 2-bit base code to ASCII, forced to 0x00 when the lane
// carries no valid base.
module gene_lane_decode
  import gene_pkg::*;
(
  input  logic [1:0] base,
  input  logic       keep,
  output logic [7:0] ascii
);

  assign ascii = keep ? base2ascii(base) : 8'h00;

endmodule

// File: rtl/gene_unpacker.sv
// Streaming 2-bit-packed nucleotide to ASCII unpacker. A word is held in a
// shift register and drained OUT_LANES bases per beat; the final beat of a
// word overlaps with accepting the next one so back-to-back words have no
// bubble. Optional per-base counters are enabled by defining
// GENE_UNPACK_BASE_COUNT_EN.
module gene_unpacker
  import gene_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_LANES = 1,
  parameter int CNT_W     = $clog2(IN_W/2) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic [CNT_W-1:0]       in_count,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_LANES-1:0] out_data,
  output logic [OUT_LANES-1:0]   out_keep,
  output logic                   out_last
`ifdef GENE_UNPACK_BASE_COUNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [31:0]            cnt_a,
  output logic [31:0]            cnt_c,
  output logic [31:0]            cnt_g,
  output logic [31:0]            cnt_t
`endif
);

  localparam int               NBASES = IN_W / 2;
  localparam logic [CNT_W-1:0] LANES  = CNT_W'(OUT_LANES);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(NBASES);

  state_t           state, state_nx;
  logic [IN_W-1:0]  sr;
  logic [CNT_W-1:0] rem;
  logic             last_q;
  logic [CNT_W-1:0] cnt_eff;
  logic             final_beat;
  logic             beat;
  logic             load;
  logic             shift;

  // A count of 0 or beyond the word size means a full word.
  assign cnt_eff    = (in_count == '0 || in_count > FULL) ? FULL : in_count;
  assign final_beat = (rem <= LANES);
  assign out_last   = final_beat & last_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and handshakes; in_ready opens on the final beat so the next
  // word loads in the same cycle the current one finishes.
  always_comb begin
    state_nx  = state;
    out_valid = (state == DRAIN);
    beat      = out_valid & out_ready;
    in_ready  = (state == IDLE) | (beat & final_beat);
    load      = in_valid & in_ready;
    shift     = beat & ~final_beat;
    if (load)                    state_nx = DRAIN;
    else if (beat & final_beat)  state_nx = IDLE;
  end

  // Word holding register: load, shift down one beat, or clear when drained
  // so keep/data read zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      rem    <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      sr     <= in_data;
      rem    <= cnt_eff;
      last_q <= in_last;
    end else if (shift) begin
      sr     <= sr >> (2 * OUT_LANES);
      rem    <= rem - LANES;
    end else if (beat) begin
      sr     <= '0;
      rem    <= '0;
      last_q <= 1'b0;
    end
  end

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
    assign out_keep[j] = (CNT_W'(j) < rem);
    gene_lane_decode u_dec (
      .base  (sr[2*j+1:2*j]),
      .keep  (out_keep[j]),
      .ascii (out_data[8*j+7:8*j])
    );
  end

`ifdef GENE_UNPACK_BASE_COUNT_EN
  logic [31:0] inc_a, inc_c, inc_g, inc_t;

  // Tally kept lanes of the current beat by base.
  always_comb begin
    inc_a = '0;
    inc_c = '0;
    inc_g = '0;
    inc_t = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      if (out_keep[j]) begin
        case (sr[2*j +: 2])
          BASE_A:  inc_a = inc_a + 32'd1;
          BASE_C:  inc_c = inc_c + 32'd1;
          BASE_T:  inc_t = inc_t + 32'd1;
          default: inc_g = inc_g + 32'd1;
        endcase
      end
    end
  end

  // Free-running wrapping counters; clear wins over a same-cycle beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_c <= '0;
      cnt_g <= '0;
      cnt_t <= '0;
    end else if (cnt_clr) begin
      cnt_a <= '0;
      cnt_c <= '0;
      cnt_g <= '0;
      cnt_t <= '0;
    end else if (beat) begin
      cnt_a <= cnt_a + inc_a;
      cnt_c <= cnt_c + inc_c;
      cnt_g <= cnt_g + inc_g;
      cnt_t <= cnt_t + inc_t;
    end
  end
`endif

endmodule
